// File: rtl/data_in_fifo_teg_if.sv
// Write handshake, bus read/flush controls and status for data_in_fifo_teg.
// DATA_IN_STATUS_EN adds the stat_E status-read strobe.
interface data_in_fifo_teg_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] In;
   logic             in_valid;
   logic             in_ready;
   logic             E;
   logic             flush;
   logic             empty;
   logic             full;
   logic [CW-1:0]    count;
   logic             ovf;
`ifdef DATA_IN_STATUS_EN
   logic             stat_E;

   modport master (output In, in_valid, E, flush, stat_E,
                   input  in_ready, empty, full, count, ovf);
   modport slave  (input  In, in_valid, E, flush, stat_E,
                   output in_ready, empty, full, count, ovf);
`else
   modport master (output In, in_valid, E, flush,
                   input  in_ready, empty, full, count, ovf);
   modport slave  (input  In, in_valid, E, flush,
                   output in_ready, empty, full, count, ovf);
`endif
endinterface

// File: rtl/data_in_fifo_teg.sv
// FWFT input FIFO driving the head word onto a tri-state W-bus; DATA_IN_STATUS_EN adds a status read.
// Latency: a written word is visible on the bus one edge later; bus read is combinational (zero latency).
// Backpressure: in_ready = !full; a word offered while full is taken only with a same-edge pop, else dropped and ovf set.
module data_in_fifo_teg #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   data_in_fifo_teg_if.slave bus,
   output tri   [WIDTH-1:0] Out_Bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    cnt;
   logic             ovf_q;
   logic             empty;
   logic             full;
   logic             push;
   logic             pop;
   logic             drive;
   logic [WIDTH-1:0] word;

   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));
   assign pop   = bus.E && !empty;
   assign push  = bus.in_valid && (!full || pop);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         ovf_q  <= 1'b0;
      end else if (bus.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      cnt <= cnt + CW'(1);
         else if (pop && !push) cnt <= cnt - CW'(1);
         if (bus.in_valid && full && !pop) ovf_q <= 1'b1;
      end
   end

   // Storage is never reset; the clr gate keeps a reset edge from landing a write.
   always_ff @(posedge clk) begin
      if (clr && !bus.flush && push) mem[wr_ptr] <= bus.In;
   end

   always_comb begin
      word  = '0;
      drive = bus.E;
      if (bus.E) begin
         if (!empty) word = mem[rd_ptr];
      end
`ifdef DATA_IN_STATUS_EN
      else if (bus.stat_E) begin
         drive        = 1'b1;
         word[0]      = empty;
         word[1]      = full;
         word[2]      = ovf_q;
         word[3 +: CW] = cnt;
      end
`endif
   end

   assign Out_Bus = drive ? word : {WIDTH{1'bz}};

   assign bus.in_ready = !full;
   assign bus.empty    = empty;
   assign bus.full     = full;
   assign bus.count    = cnt;
   assign bus.ovf      = ovf_q;
endmodule
